scratchpad_port_arbiter: RTL and testbench

- Shares one single-port 4096x32 scratchpad RAM between two Avalon-MM requesters:
  - m0: the processor core data master.
  - m1: the fingerprint/DMA agent.
- Round-robin arbitration, with an optional bounded lock for atomic read-modify-write sequences.
- Sits between the two requesters and the RAM's single s1 port; the RAM has 1-cycle read latency (registered address, unregistered q).

---
 rtl/scratchpad_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 94 +++++++++
 rtl/scratchpad_port_arbiter.sv | 120 ++++++++++++
 tb/tb_scratchpad_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scratchpad_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : scratchpad_arb_pkg
// Brief   : Shared defaults and requester ids for the scratchpad arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package scratchpad_arb_pkg;

    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 32;
    localparam int LOCK_MAX_DEF = 8;
    localparam int LOCK_CNT_W   = 8;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-way round-robin / fixed-priority grant with bounded lock.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
    import scratchpad_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int PRIO_M0  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  logic       i_force_valid,
    input  logic       i_force_id,
    output logic [1:0] o_grant,
    output logic       o_max_clear,
    output logic       o_lock_owner
);

    localparam logic [LOCK_CNT_W-1:0] c_LOCK_MAX = LOCK_CNT_W'(LOCK_MAX);

    logic                  r_last_grant;
    logic                  r_lock_valid;
    logic                  r_lock_owner;
    logic [LOCK_CNT_W-1:0] r_lock_cnt;

    logic       w_lock_active;
    logic       w_cnt_max;
    logic       w_winner;
    logic [1:0] w_grant;

    // The lock only holds while its owner keeps lock asserted, even when idle.
    assign w_lock_active = r_lock_valid & i_lock[r_lock_owner];
    assign w_cnt_max     = (r_lock_cnt == c_LOCK_MAX);

    always_comb begin
        w_grant = 2'b00;
        if (w_lock_active) begin
            w_grant[r_lock_owner] = i_req[r_lock_owner];
        end else if (i_req == 2'b01) begin
            w_grant = 2'b01;
        end else if (i_req == 2'b10) begin
            w_grant = 2'b10;
        end else if (i_req == 2'b11) begin
            if (i_force_valid) begin
                w_grant[i_force_id] = 1'b1;
            end else if (PRIO_M0 != 0) begin
                w_grant[REQ_M0] = 1'b1;
            end else begin
                w_grant[other_id(r_last_grant)] = 1'b1;
            end
        end
    end

    assign w_winner = w_grant[REQ_M1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= REQ_M1;
            r_lock_valid <= 1'b0;
            r_lock_owner <= REQ_M0;
            r_lock_cnt   <= '0;
        end else begin
            if (|w_grant) begin
                r_last_grant <= w_winner;
            end
            if (w_lock_active) begin
                if (w_cnt_max) begin
                    r_lock_valid <= 1'b0;
                    r_lock_cnt   <= '0;
                end else begin
                    r_lock_cnt <= r_lock_cnt + LOCK_CNT_W'(1);
                end
            end else if ((|w_grant) && i_lock[w_winner]) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= w_winner;
                r_lock_cnt   <= LOCK_CNT_W'(1);
            end else begin
                r_lock_valid <= 1'b0;
                r_lock_cnt   <= '0;
            end
        end
    end

    assign o_grant      = w_grant;
    assign o_max_clear  = w_lock_active & w_cnt_max;
    assign o_lock_owner = r_lock_owner;

endmodule
`default_nettype wire

// File: rtl/scratchpad_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : scratchpad_port_arbiter
// Brief   : Shares one single-port scratchpad RAM between two Avalon-MM masters.
// Revision: 1.0 - initial release
// ============================================================================
module scratchpad_port_arbiter
    import scratchpad_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int PRIO_M0  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic                m0_lock,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic                m1_lock,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic       w_max_clear;
    logic       w_lock_owner;
    logic       w_sel_m1;
    logic       w_rd_gnt;

    logic r_force_valid;
    logic r_force_id;
    logic r_rd_pend;
    logic r_rd_owner;

    assign w_req = {m1_read | m1_write, m0_read | m0_write};

    rr_arb2 #(
        .LOCK_MAX (LOCK_MAX),
        .PRIO_M0  (PRIO_M0)
    ) u_arb (
        .clk           (clk),
        .rst           (reset),
        .i_req         (w_req),
        .i_lock        ({m1_lock, m0_lock}),
        .i_force_valid (r_force_valid),
        .i_force_id    (r_force_id),
        .o_grant       (w_grant),
        .o_max_clear   (w_max_clear),
        .o_lock_owner  (w_lock_owner)
    );

    // After a lock times out, the starved side owns the next contested cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_force_valid <= 1'b0;
            r_force_id    <= REQ_M0;
        end else if (w_max_clear) begin
            r_force_valid <= 1'b1;
            r_force_id    <= other_id(w_lock_owner);
        end else if (r_force_valid && (&w_req) && w_grant[r_force_id]) begin
            r_force_valid <= 1'b0;
        end
    end

    assign w_sel_m1       = w_grant[REQ_M1];
    assign ram_address    = w_sel_m1 ? m1_address    : m0_address;
    assign ram_byteenable = w_sel_m1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = w_sel_m1 ? m1_writedata  : m0_writedata;
    assign ram_chipselect = |w_grant;
    assign ram_write      = (w_grant[REQ_M0] & m0_write) | (w_grant[REQ_M1] & m1_write);
    assign ram_clken      = 1'b1;

    // Read+write together is treated as a write, so it never opens a read slot.
    assign w_rd_gnt = (w_grant[REQ_M0] & m0_read & ~m0_write)
                    | (w_grant[REQ_M1] & m1_read & ~m1_write);

    assign m0_waitrequest = w_req[REQ_M0] & ~w_grant[REQ_M0];
    assign m1_waitrequest = w_req[REQ_M1] & ~w_grant[REQ_M1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= REQ_M0;
        end else begin
            r_rd_pend  <= w_rd_gnt;
            r_rd_owner <= w_sel_m1;
        end
    end

    assign m0_readdatavalid = r_rd_pend & (r_rd_owner == REQ_M0);
    assign m1_readdatavalid = r_rd_pend & (r_rd_owner == REQ_M1);
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

    a_m0_rd_wr : assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
    a_m1_rd_wr : assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_scratchpad_port_arbiter
// Brief   : Vector table plus read scoreboard for the scratchpad arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_scratchpad_port_arbiter;

    localparam logic [1:0] c_IDL = 2'd0;
    localparam logic [1:0] c_RD  = 2'd1;
    localparam logic [1:0] c_WR  = 2'd2;

    typedef struct {
        logic [1:0]  op0;
        logic [11:0] a0;
        logic [31:0] d0;
        logic [3:0]  be0;
        logic [1:0]  op1;
        logic [11:0] a1;
        logic [31:0] d1;
        logic [3:0]  be1;
        logic [3:0]  ex;   // {wait0, wait1, prio_wait0, prio_wait1}
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk, reset;
    logic [11:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata, ram_readdata;

    logic        p_m0_waitrequest, p_m1_waitrequest, p_m0_readdatavalid, p_m1_readdatavalid;
    logic [31:0] p_m0_readdata, p_m1_readdata, p_ram_writedata;
    logic [11:0] p_ram_address;
    logic [3:0]  p_ram_byteenable;
    logic        p_ram_chipselect, p_ram_write, p_ram_clken;

    logic [31:0] mem [0:4095];
    logic [11:0] r_ram_addr;
    logic [31:0] shadow [0:4095];

    exp_t sbq[$];
    exp_t e;
    vec_t vt[$];
    vec_t v;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    scratchpad_port_arbiter #(.LOCK_MAX(8), .PRIO_M0(0)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_lock(m0_lock), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_lock(m1_lock), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    scratchpad_port_arbiter #(.LOCK_MAX(8), .PRIO_M0(1)) dut_p (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_lock(m0_lock), .m0_writedata(m0_writedata),
        .m0_waitrequest(p_m0_waitrequest), .m0_readdata(p_m0_readdata),
        .m0_readdatavalid(p_m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_lock(m1_lock), .m1_writedata(m1_writedata),
        .m1_waitrequest(p_m1_waitrequest), .m1_readdata(p_m1_readdata),
        .m1_readdatavalid(p_m1_readdatavalid),
        .ram_address(p_ram_address), .ram_byteenable(p_ram_byteenable),
        .ram_chipselect(p_ram_chipselect), .ram_write(p_ram_write),
        .ram_writedata(p_ram_writedata), .ram_clken(p_ram_clken), .ram_readdata(ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered address, unregistered q, preloaded under reset.
    always @(posedge clk) begin
        if (reset) begin
            mem[12'h000] <= 32'h0000_1000;
            mem[12'h800] <= 32'h0000_2000;
            mem[12'h010] <= 32'hDEAD_BEEF;
            mem[12'h123] <= 32'hAAAA_AAAA;
            mem[12'h200] <= 32'h0;
            mem[12'h201] <= 32'h0;
        end else if (ram_chipselect && ram_write) begin
            for (int b = 0; b < 4; b++)
                if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
        r_ram_addr <= ram_address;
    end
    assign ram_readdata = mem[r_ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic vec_t mk(input logic [1:0] op0, input logic [11:0] a0,
                                input logic [31:0] d0, input logic [3:0] be0,
                                input logic [1:0] op1, input logic [11:0] a1,
                                input logic [31:0] d1, input logic [3:0] be1,
                                input logic [3:0] ex);
        vec_t t;
        t.op0 = op0; t.a0 = a0; t.d0 = d0; t.be0 = be0;
        t.op1 = op1; t.a1 = a1; t.d1 = d1; t.be1 = be1;
        t.ex  = ex;
        return t;
    endfunction

    task automatic clear_inputs();
        m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0;
        m1_read = 1'b0; m1_write = 1'b0; m1_lock = 1'b0;
        m0_address = 12'h0; m1_address = 12'h0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = 32'h0; m1_writedata = 32'h0;
    endtask

    task automatic push_exp(input logic port, input logic [31:0] data);
        exp_t x;
        x.port = port; x.data = data; x.due = cyc + 1;
        sbq.push_back(x);
    endtask

    // Read-return monitor: each scoreboard entry must land exactly at its due cycle.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (e.port == 1'b0) begin
                chk("rdv0", {31'b0, m0_readdatavalid}, 32'd1);
                chk("rdata0", m0_readdata, e.data);
                chk("rdv1_quiet", {31'b0, m1_readdatavalid}, 32'd0);
            end else begin
                chk("rdv1", {31'b0, m1_readdatavalid}, 32'd1);
                chk("rdata1", m1_readdata, e.data);
                chk("rdv0_quiet", {31'b0, m0_readdatavalid}, 32'd0);
            end
        end else if (m0_readdatavalid || m1_readdatavalid) begin
            chk("rdv_unexpected", {30'b0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
        end
    end

    initial begin
        int   stall, pstall;
        logic got, pgot, g0, g1;
        logic [11:0] ea;

        reset = 1'b1;
        clear_inputs();
        shadow[12'h000] = 32'h0000_1000;
        shadow[12'h800] = 32'h0000_2000;
        shadow[12'h010] = 32'hDEAD_BEEF;
        shadow[12'h123] = 32'hAAAA_AAAA;
        shadow[12'h200] = 32'h0;
        shadow[12'h201] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
        chk("rst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
        chk("rst_cs", {31'b0, ram_chipselect}, 32'd0);
        chk("rst_wr", {31'b0, ram_write}, 32'd0);
        chk("rst_clken", {31'b0, ram_clken}, 32'd1);
        chk("rst_wait", {30'b0, m1_waitrequest, m0_waitrequest}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_IDL, 12'h000, 32'h0, 4'hF, 4'b0000));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(c_RD, 12'h000, 32'h0, 4'hF, c_RD, 12'h800, 32'h0, 4'hF,
                            (k % 2 == 0) ? 4'b0101 : 4'b1001));
        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_IDL, 12'h000, 32'h0, 4'hF, 4'b0000));
        vt.push_back(mk(c_RD,  12'h010, 32'h0, 4'hF, c_IDL, 12'h000, 32'h0, 4'hF, 4'b0000));
        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_IDL, 12'h000, 32'h0, 4'hF, 4'b0000));
        vt.push_back(mk(c_RD,  12'h010, 32'h0, 4'hF, c_RD,  12'h000, 32'h0, 4'hF, 4'b1001));
        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_RD,  12'h800, 32'h0, 4'hF, 4'b0000));
        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_WR,  12'h123, 32'h1122_3344, 4'b0101, 4'b0000));
        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_RD,  12'h123, 32'h0, 4'hF, 4'b0000));
        vt.push_back(mk(c_WR,  12'h200, 32'hCAFE_F00D, 4'hF, c_WR, 12'h201, 32'h1234_5678, 4'b1100, 4'b0101));
        vt.push_back(mk(c_RD,  12'h200, 32'h0, 4'hF, c_WR,  12'h201, 32'h1234_5678, 4'b1100, 4'b1001));
        vt.push_back(mk(c_RD,  12'h200, 32'h0, 4'hF, c_RD,  12'h201, 32'h0, 4'hF, 4'b0101));
        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_RD,  12'h201, 32'h0, 4'hF, 4'b0000));
        vt.push_back(mk(c_IDL, 12'h000, 32'h0, 4'hF, c_IDL, 12'h000, 32'h0, 4'hF, 4'b0000));

        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            @(negedge clk);
            m0_read = (v.op0 == c_RD); m0_write = (v.op0 == c_WR); m0_lock = 1'b0;
            m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.be0;
            m1_read = (v.op1 == c_RD); m1_write = (v.op1 == c_WR); m1_lock = 1'b0;
            m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.be1;
            #1;
            g0 = (v.op0 != c_IDL) && !v.ex[3];
            g1 = (v.op1 != c_IDL) && !v.ex[2];
            ea = g1 ? v.a1 : v.a0;
            chk($sformatf("v%0d_wait0", i), {31'b0, m0_waitrequest}, {31'b0, v.ex[3]});
            chk($sformatf("v%0d_wait1", i), {31'b0, m1_waitrequest}, {31'b0, v.ex[2]});
            chk($sformatf("v%0d_prio_wait0", i), {31'b0, p_m0_waitrequest}, {31'b0, v.ex[1]});
            chk($sformatf("v%0d_prio_wait1", i), {31'b0, p_m1_waitrequest}, {31'b0, v.ex[0]});
            chk($sformatf("v%0d_cs", i), {31'b0, ram_chipselect}, {31'b0, g0 | g1});
            chk($sformatf("v%0d_ramwr", i), {31'b0, ram_write},
                {31'b0, (g0 && v.op0 == c_WR) || (g1 && v.op1 == c_WR)});
            chk($sformatf("v%0d_addr", i), {20'b0, ram_address}, {20'b0, ea});
            if (g0 && v.op0 == c_RD) push_exp(1'b0, shadow[v.a0]);
            if (g1 && v.op1 == c_RD) push_exp(1'b1, shadow[v.a1]);
            if (g0 && v.op0 == c_WR) begin
                chk($sformatf("v%0d_wdata", i), ram_writedata, v.d0);
                chk($sformatf("v%0d_be", i), {28'b0, ram_byteenable}, {28'b0, v.be0});
                shadow[v.a0] = merge(shadow[v.a0], v.d0, v.be0);
            end
            if (g1 && v.op1 == c_WR) begin
                chk($sformatf("v%0d_wdata", i), ram_writedata, v.d1);
                chk($sformatf("v%0d_be", i), {28'b0, ram_byteenable}, {28'b0, v.be1});
                shadow[v.a1] = merge(shadow[v.a1], v.d1, v.be1);
            end
        end
        chk("byte_merge_ref", shadow[12'h123], 32'hAA22_AA44);

        // Lock bound: m0 locks first, m1 joins one cycle later and must wait LOCK_MAX cycles.
        @(negedge clk);
        clear_inputs();
        m0_write = 1'b1; m0_lock = 1'b1; m0_address = 12'h300; m0_writedata = 32'd0;
        #1;
        chk("lk_first_m0", {31'b0, m0_waitrequest}, 32'd0);
        stall = 0; pstall = 0; got = 1'b0; pgot = 1'b0;
        for (int k = 1; k <= 20 && !(got && pgot); k++) begin
            @(negedge clk);
            m0_writedata = k;
            m1_write = 1'b1; m1_address = 12'h301; m1_writedata = 32'h5555_5555;
            #1;
            if (!got) begin
                if (m1_waitrequest) stall++;
                else begin
                    got = 1'b1;
                    chk("lk_m0_blocked", {31'b0, m0_waitrequest}, 32'd1);
                end
            end
            if (!pgot) begin
                if (p_m1_waitrequest) pstall++;
                else begin
                    pgot = 1'b1;
                    chk("lk_prio_m0_blocked", {31'b0, p_m0_waitrequest}, 32'd1);
                end
            end
        end
        chk("lk_stall", stall, 32'd8);
        chk("lk_stall_prio", pstall, 32'd8);
        @(negedge clk);
        m1_write = 1'b0;
        #1;
        chk("lk_m0_regain", {31'b0, m0_waitrequest}, 32'd0);
        chk("lk_prio_m0_regain", {31'b0, p_m0_waitrequest}, 32'd0);
        @(negedge clk);
        clear_inputs();

        // Reset lands right after m1's read grant: its response must vanish.
        @(negedge clk);
        m1_read = 1'b1; m1_address = 12'h800;
        #1;
        chk("rst_m1_gnt", {31'b0, m1_waitrequest}, 32'd0);
        @(posedge clk);
        reset = 1'b1;
        #1;
        chk("rst_rdv1_dropped", {31'b0, m1_readdatavalid}, 32'd0);
        chk("rst_rdv0_dropped", {31'b0, m0_readdatavalid}, 32'd0);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
        @(negedge clk);
        m0_read = 1'b1; m0_address = 12'h010;
        m1_read = 1'b1; m1_address = 12'h800;
        #1;
        chk("post_rst_wait0", {31'b0, m0_waitrequest}, 32'd0);
        chk("post_rst_wait1", {31'b0, m1_waitrequest}, 32'd1);
        push_exp(1'b0, shadow[12'h010]);
        @(negedge clk);
        m0_read = 1'b0;
        #1;
        chk("post_rst_m1", {31'b0, m1_waitrequest}, 32'd0);
        push_exp(1'b1, shadow[12'h800]);
        @(negedge clk);
        clear_inputs();

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
